bin_to_bcd_seq: RTL
===================

Name: bin_to_bcd_seq

Overview:
- Parametrised, multi-cycle binary-to-BCD converter using shift-add-3 (double dabble), one input bit per clock.
- Handshake is start/busy/done, with optional signed mode, overflow detection and a leading-zero blank mask.
- Sits between a datapath value (PC, register, counter) and the multi-digit seven-segment driver.
- Replaces the combinational converter where timing or width makes a single-cycle loop impractical.

Parameters:
- BIN_W, 13, width of binary input (>=2).
- DIGITS, 4, number of BCD digits produced (>=1).
- SIGNED, 0, 1 = input is two's complement; magnitude converted, sign reported on neg.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request conversion of bin_in; sampled only when accepted (see Behaviour).
- bin_in  input  BIN_W  operand; captured on the accepting edge only.
- busy  output  1  high while a conversion is in progress.
- done  output  1  single-cycle pulse: results valid and updated.
- bcd_out  output  4*DIGITS  digit i at bits [4i+3:4i], i=0 is ones; held until next done.
- neg  output  1  sign of the last converted operand (always 0 when SIGNED=0).
- overflow  output  1  last result exceeded 10^DIGITS-1; bcd_out then holds value mod 10^DIGITS.
- blank_mask  output  DIGITS  bit i=1 if digit i and all higher digits are 0, for i>=1; bit 0 always 0.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - FSM goes to IDLE.
  - busy=0, done=0, bcd_out=0, neg=0, overflow=0, blank_mask={DIGITS-1{1},0}.
  - Shift register, bit counter and sticky overflow are cleared.
- FSM states: IDLE, CONV, DONE.
- IDLE -> CONV: when start=1 at a rising edge (edge k).
  - Capture the magnitude: bin_in, or its two's-complement absolute value if SIGNED=1 and bin_in MSB=1.
  - Capture the sign into an internal register.
  - Clear the BCD scratch and overflow scratch; load counter = BIN_W.
  - busy=1 from edge k.
- CONV: one iteration per edge (edges k+1 .. k+BIN_W).
  - Every scratch digit >=5 gets +3.
  - Then shift left {digits, magnitude} by one.
  - The bit shifted out of the top digit's MSB is ORed into sticky overflow.
  - Decrement counter.
- Final iteration (edge k+BIN_W):
  - Write the corrected result directly to bcd_out, with neg, overflow and blank_mask.
  - done=1, busy=0, go to DONE.
  - Total latency: done high in the cycle after edge k+BIN_W, i.e. BIN_W edges after the accepting edge.
- DONE: lasts one cycle.
  - done returns to 0 next edge; go to IDLE.
  - If start=1 in DONE, accept immediately (acts as IDLE->CONV), giving back-to-back throughput of one conversion per BIN_W+1 cycles.
- start while busy=1 is ignored; bin_in changes during CONV have no effect.
- Outputs bcd_out/neg/overflow/blank_mask change only on the done edge (and reset); never expose intermediate scratch.
- SIGNED=1 with the most negative input -2^(BIN_W-1): magnitude 2^(BIN_W-1) fits in BIN_W unsigned bits; convert correctly, neg=1.
- Zero input: bcd_out=0, neg=0 even if the signed path is taken.
- Overflow: digits below the top hold the exact value mod 10^DIGITS, since add-3 corrections are digit-local.
- Reset asserted mid-CONV: abort, no done pulse, outputs return to reset values.
- No combinational path from inputs to outputs.

Test Plan:
- Defaults, bin_in=8191, start 1 cycle -> busy for 13 cycles, done pulse 13 edges after accept, bcd_out=16'h8191, overflow=0, blank_mask=4'b0000.
- Defaults, bin_in=0 -> bcd_out=16'h0000, blank_mask=4'b1110. Then bin_in=42 -> 16'h0042, blank_mask=4'b1100.
- BIN_W=14, DIGITS=4: bin_in=9999 -> 16'h9999, overflow=0. bin_in=10000 -> overflow=1, bcd_out=16'h0000. bin_in=12345 -> overflow=1, bcd_out=16'h2345.
- SIGNED=1, BIN_W=12, DIGITS=4:
  - -1234 (12'hB2E) -> neg=1, bcd_out=16'h1234.
  - -2048 -> neg=1, 16'h2048.
  - 2047 -> neg=0, 16'h2047.
- Handshake:
  - start held high continuously with changing bin_in -> only values present on accepting edges are converted; one done every 14 cycles (BIN_W=13); mid-CONV changes ignored.
- rst_n pulsed low 5 cycles after accepting 8191 -> immediate busy=0, outputs at reset values, no done. Next start with 77 -> 16'h0077, correct latency.

Source files
------------

// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and result bundle for the sequential binary-to-BCD converter.
// master drives start/bin_in, slave (the converter) drives the result side.
interface bin_to_bcd_seq_if #(
   parameter int BIN_W  = 13,
   parameter int DIGITS = 4
) ();
   logic                  start;
   logic [BIN_W-1:0]      bin_in;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   bcd_out;
   logic                  neg;
   logic                  overflow;
   logic [DIGITS-1:0]     blank_mask;

   modport master (
      output start, bin_in,
      input  busy, done, bcd_out, neg, overflow, blank_mask
   );

   modport slave (
      input  start, bin_in,
      output busy, done, bcd_out, neg, overflow, blank_mask
   );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Multi-cycle binary-to-BCD converter (double dabble, one input bit per clock).
// Accepts an operand on start, iterates BIN_W times, then publishes digits,
// sign, overflow and a leading-zero blank mask together with a one-cycle done.
// Published results are held until the next done; scratch is never exposed.
module bin_to_bcd_seq #(
   parameter int BIN_W  = 13,
   parameter int DIGITS = 4,
   parameter int SIGNED = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   bin_to_bcd_seq_if.slave     bus
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(BIN_W);
   localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [BIN_W-1:0]  BIN_ONE   = {{(BIN_W-1){1'b0}}, 1'b1};
   localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   // add-3 correction applied to one BCD digit before each shift
   function automatic logic [3:0] add3(input logic [3:0] d);
      if (d >= 4'd5) begin
         return d + 4'd3;
      end else begin
         return d;
      end
   endfunction

   // bit i set when digit i and every digit above it are zero; ones digit never blanked
   function automatic logic [DIGITS-1:0] blank_of(input logic [BCD_W-1:0] d);
      logic [DIGITS-1:0] m;
      logic              hz;
      m  = {DIGITS{1'b0}};
      hz = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         hz   = hz & (d[4*i +: 4] == 4'd0);
         m[i] = hz;
      end
      return m;
   endfunction

   state_t              state_r, state_s;
   logic [BIN_W-1:0]    mag_r, mag_s;
   logic [BCD_W-1:0]    scratch_r, scratch_s;
   logic                sticky_r, sticky_s;
   logic                sign_r, sign_s;
   logic [CNT_W-1:0]    cnt_r, cnt_s;
   logic                busy_r, busy_s;
   logic                done_r, done_s;
   logic [BCD_W-1:0]    bcd_r, bcd_s;
   logic                neg_r, neg_s;
   logic                ovf_r, ovf_s;
   logic [DIGITS-1:0]   blank_r, blank_s;

   logic [BCD_W-1:0]    corr_s;
   logic [BCD_W-1:0]    shifted_s;
   logic                shift_out_s;
   logic                accept_s;
   logic                neg_in_s;
   logic [BIN_W-1:0]    mag_in_s;

   // one double-dabble step: correct every digit, then shift in the next magnitude bit
   always_comb begin
      corr_s = {BCD_W{1'b0}};
      for (int i = 0; i < DIGITS; i++) begin
         corr_s[4*i +: 4] = add3(scratch_r[4*i +: 4]);
      end
      shifted_s   = {corr_s[BCD_W-2:0], mag_r[BIN_W-1]};
      shift_out_s = corr_s[BCD_W-1];
   end

   // operand capture: magnitude and sign of bin_in (two's complement when SIGNED)
   always_comb begin
      accept_s = bus.start & ((state_r == IDLE) | (state_r == DONE));
      neg_in_s = (SIGNED != 0) & bus.bin_in[BIN_W-1];
      if (neg_in_s) begin
         mag_in_s = ~bus.bin_in + BIN_ONE;
      end else begin
         mag_in_s = bus.bin_in;
      end
   end

   // next-state and next-register values for the control FSM and datapath
   always_comb begin
      state_s   = state_r;
      mag_s     = mag_r;
      scratch_s = scratch_r;
      sticky_s  = sticky_r;
      sign_s    = sign_r;
      cnt_s     = cnt_r;
      busy_s    = busy_r;
      done_s    = 1'b0;
      bcd_s     = bcd_r;
      neg_s     = neg_r;
      ovf_s     = ovf_r;
      blank_s   = blank_r;
      case (state_r)
         IDLE, DONE: begin
            if (accept_s) begin
               state_s   = CONV;
               mag_s     = mag_in_s;
               sign_s    = neg_in_s;
               scratch_s = {BCD_W{1'b0}};
               sticky_s  = 1'b0;
               cnt_s     = CNT_LOAD;
               busy_s    = 1'b1;
            end else begin
               state_s   = IDLE;
               busy_s    = 1'b0;
            end
         end
         CONV: begin
            scratch_s = shifted_s;
            mag_s     = {mag_r[BIN_W-2:0], 1'b0};
            sticky_s  = sticky_r | shift_out_s;
            cnt_s     = cnt_r - CNT_ONE;
            if (cnt_r == CNT_ONE) begin
               state_s = DONE;
               busy_s  = 1'b0;
               done_s  = 1'b1;
               bcd_s   = shifted_s;
               neg_s   = sign_r;
               ovf_s   = sticky_r | shift_out_s;
               blank_s = blank_of(shifted_s);
            end else begin
               state_s = CONV;
            end
         end
         default: begin
            state_s = IDLE;
            busy_s  = 1'b0;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // datapath scratch and published result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mag_r     <= {BIN_W{1'b0}};
         scratch_r <= {BCD_W{1'b0}};
         sticky_r  <= 1'b0;
         sign_r    <= 1'b0;
         cnt_r     <= {CNT_W{1'b0}};
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         bcd_r     <= {BCD_W{1'b0}};
         neg_r     <= 1'b0;
         ovf_r     <= 1'b0;
         blank_r   <= BLANK_RST;
      end else begin
         mag_r     <= mag_s;
         scratch_r <= scratch_s;
         sticky_r  <= sticky_s;
         sign_r    <= sign_s;
         cnt_r     <= cnt_s;
         busy_r    <= busy_s;
         done_r    <= done_s;
         bcd_r     <= bcd_s;
         neg_r     <= neg_s;
         ovf_r     <= ovf_s;
         blank_r   <= blank_s;
      end
   end

   assign bus.busy       = busy_r;
   assign bus.done       = done_r;
   assign bus.bcd_out    = bcd_r;
   assign bus.neg        = neg_r;
   assign bus.overflow   = ovf_r;
   assign bus.blank_mask = blank_r;

endmodule
